mps_pwr_seq_ctrl: RTL and testbench
===================================

// Module: mps_pwr_seq_ctrl
// PURPOSE
// - Sequences the MPS power stage on/off: phase check, discharge relay, slow-charge relay, DC-link charge, main contactor.
// - Driven by single-cycle on/off request pulses from the system FSM.
// - Returns its state, done pulses and fault code to the system FSM.
// - Every wait step has debounce and timeout. Interlock forces an immediate safe state.
// PARAMETERS
// DEB_CYC   16           consecutive cycles a wait condition must hold before advancing (>=1)
// TMO_CYC   50_000_000   cycles allowed in any wait state before timeout fault (> DEB_CYC)
// CNT_W     32           width of debounce/timeout counters
// DC_ON_TH  32'h43820000 DC-link charged threshold, IEEE-754 single (260.0 V)
// DC_OFF_TH 32'h41200000 DC-link discharged threshold, IEEE-754 single (10.0 V)
// PORTS
// i_clk        in   1  system clock
// i_rst        in   1  synchronous reset, active-low
// i_op_on      in   1  on-request pulse (1 cycle)
// i_op_off     in   1  off-request pulse (1 cycle)
// i_intl       in   1  interlock, level
// i_fault_clr  in   1  fault clear pulse
// i_phase_ok   in   1  AC phase monitor OK
// i_dis_fb     in   1  discharge relay feedback (1=engaged)
// i_slow_fb    in   1  slow-charge relay feedback (1=closed)
// i_main_fb    in   1  main contactor feedback (1=closed)
// i_dc_v       in   32 DC-link voltage, IEEE-754 single
// o_dis_on     out  1  discharge relay drive (1=engaged)
// o_slow_on    out  1  slow-charge relay drive
// o_main_on    out  1  main contactor drive
// o_state      out  4  current state code
// o_on_done    out  1  high while in ON
// o_off_done   out  1  1-cycle pulse on OFF_DIS->IDLE
// o_fault      out  1  high while in FAULT
// o_fault_code out  4  state code where fault arose; 15=interlock; 0 when no fault
// BEHAVIOUR
// - Reset (i_rst=0 at posedge): state=IDLE, o_dis_on=1, o_fault_code=0, all other outputs 0, counters 0.
// - Outputs are registered and change on the same edge that enters the state.
// - States, with relay drives and exit conditions:
//   0 IDLE: dis=1, slow=0, main=0. Goes to 1 on i_op_on.
//   1 PHASE_CHK: drives unchanged. Waits for i_phase_ok=1.
//   2 DIS_OFF: dis=0. Waits for i_dis_fb=0.
//   3 SLOW_ON: slow=1. Waits for i_slow_fb=1.
//   4 DC_CHG: waits for V>=DC_ON_TH.
//   5 MAIN_ON: main=1. Waits for i_main_fb=1.
//   6 SLOW_OFF: slow=0. Waits for i_slow_fb=0.
//   7 ON: o_on_done=1. i_op_off goes to 8. i_main_fb=0 goes to FAULT with code 7.
//   8 OFF_MAIN: main=0, slow=0. Waits for i_main_fb=0 and i_slow_fb=0.
//   9 OFF_DIS: dis=1. Waits for V<=DC_OFF_TH, then goes to IDLE and pulses o_off_done.
//   10 FAULT: main=0, slow=0, dis=1. i_fault_clr with V<=DC_OFF_TH goes to IDLE and clears the code.
// - Wait states are 1-6, 8 and 9.
// - Debounce counter: increments while the condition is true and clears when it is false.
//   Advance happens on the edge ending the DEB_CYC-th consecutive true cycle.
// - Timeout counter: clears on state entry. On reaching TMO_CYC the block goes to FAULT with code = state.
//   If advance and timeout occur in the same cycle, advance wins.
// - Voltage compare: i_dc_v[31]=1 (negative/-0) is treated as 0 V.
//   Otherwise compare i_dc_v[30:0] unsigned against the threshold[30:0]; this is monotonic for positive floats.
//   NaN/Inf count as above every threshold.
// - Priority per cycle: reset > i_intl > timeout/feedback fault > i_op_off > i_op_on.
//   - i_intl=1 in any state except FAULT goes to FAULT, code 15. In FAULT, i_intl held blocks the clear.
//   - i_op_off in states 1-7 aborts to OFF_MAIN. i_op_off in IDLE, 8, 9 or FAULT is ignored.
//   - i_op_on outside IDLE is ignored. i_op_on and i_op_off together in IDLE: ignored.
// - Counters saturate and never wrap. Both clear on every state change.
// - o_fault_code holds until cleared by the exit from FAULT.
// TESTING (bench params: DEB_CYC=4, TMO_CYC=200)
// - Full on sequence:
//   - i_op_on pulse, with feedbacks following drives after 10 cycles and i_dc_v ramped to 32'h438C8000 (281.0).
//   - Required: o_state steps 1..7, then o_on_done=1, main=1, slow=0, dis=0.
// - Off sequence from ON:
//   - i_op_off, main_fb drops, i_dc_v set to 32'h41100000 (9.0).
//   - Required: states 8 then 9, o_off_done pulses 1 cycle, state returns to 0, dis=1.
// - Timeout: in DC_CHG, hold i_dc_v=32'h42C80000 (100.0).
//   - Required: FAULT after 200 cycles, o_fault_code=4, all relays safe.
//   - i_fault_clr is ignored until V<=10.0 and is then accepted, leaving IDLE with code 0.
// - Interlock: assert i_intl for 1 cycle in SLOW_ON.
//   - Required: next edge enters FAULT, code 15, slow=0.
//   - i_op_on while in FAULT is ignored.
// - Debounce: i_phase_ok toggles 1,1,1,0,1,1,1,1.
//   - Required: PHASE_CHK exits only after the final 4-cycle run.
// - Reset mid-sequence: i_rst=0 for 1 cycle in MAIN_ON.
//   - Required: next cycle IDLE, dis=1, main=0, counters cleared.

Source files
------------

// File: rtl/mps_pwr_seq_ctrl.sv
// mps_pwr_seq_ctrl
// Sequences the MPS power stage on and off: phase check, discharge relay,
// slow-charge relay, DC-link charge, then main contactor. Each wait step is
// debounced and guarded by a timeout. An interlock forces the safe state at once.
//
//   code | state      | meaning
//   -----+------------+-----------------------------------------------------
//     0  | IDLE       | stage off, discharge engaged, waiting for on request
//     1  | PHASE_CHK  | waiting for AC phase monitor OK
//     2  | DIS_OFF    | discharge released, waiting for its feedback to drop
//     3  | SLOW_ON    | slow-charge relay closed, waiting for feedback
//     4  | DC_CHG     | waiting for DC-link to reach the charged threshold
//     5  | MAIN_ON    | main contactor closed, waiting for feedback
//     6  | SLOW_OFF   | slow-charge relay opened, waiting for feedback
//     7  | ON         | stage running; main feedback loss is a fault
//     8  | OFF_MAIN   | main and slow opened, waiting for both feedbacks low
//     9  | OFF_DIS    | discharge engaged, waiting for DC-link discharged
//    10  | FAULT      | safe state; leaves on clear once DC-link is discharged
module mps_pwr_seq_ctrl #(
   parameter int unsigned DEB_CYC   = 16,
   parameter int unsigned TMO_CYC   = 50_000_000,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] DC_ON_TH  = 32'h43820000,
   parameter logic [31:0] DC_OFF_TH = 32'h41200000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_op_on,
   input  logic        i_op_off,
   input  logic        i_intl,
   input  logic        i_fault_clr,
   input  logic        i_phase_ok,
   input  logic        i_dis_fb,
   input  logic        i_slow_fb,
   input  logic        i_main_fb,
   input  logic [31:0] i_dc_v,
   output logic        o_dis_on,
   output logic        o_slow_on,
   output logic        o_main_on,
   output logic [3:0]  o_state,
   output logic        o_on_done,
   output logic        o_off_done,
   output logic        o_fault,
   output logic [3:0]  o_fault_code
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PHASE_CHK = 4'd1,
      ST_DIS_OFF   = 4'd2,
      ST_SLOW_ON   = 4'd3,
      ST_DC_CHG    = 4'd4,
      ST_MAIN_ON   = 4'd5,
      ST_SLOW_OFF  = 4'd6,
      ST_ON        = 4'd7,
      ST_OFF_MAIN  = 4'd8,
      ST_OFF_DIS   = 4'd9,
      ST_FAULT     = 4'd10
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [3:0]       CODE_INTL = 4'd15;
   localparam logic [3:0]       CODE_MAIN = 4'd7;
   localparam logic [3:0]       CODE_NONE = 4'd0;

   state_t           r_state;
   logic [CNT_W-1:0] r_deb_cnt;
   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_dis_on;
   logic             r_slow_on;
   logic             r_main_on;
   logic             r_on_done;
   logic             r_off_done;
   logic             r_fault;
   logic [3:0]       r_fault_code;

   state_t           w_state_nxt;
   state_t           w_adv_state;
   logic             w_is_wait;
   logic             w_cond;
   logic             w_deb_done;
   logic             w_tmo_hit;
   logic             w_v_ge_on;
   logic             w_v_le_off;
   logic             w_abortable;
   logic             w_chg;
   logic [3:0]       w_code_nxt;
   logic [CNT_W-1:0] w_deb_nxt;
   logic [CNT_W-1:0] w_tmo_nxt;
   logic             w_dis_nxt;
   logic             w_slow_nxt;
   logic             w_main_nxt;
   logic             w_on_done_nxt;
   logic             w_off_done_nxt;
   logic             w_fault_nxt;

   // Sign bit set (negative or -0) reads as 0 V. For positive floats the raw
   // magnitude bits order the same way as the values, and NaN/Inf sort above
   // every finite threshold, so a plain unsigned compare is enough.
   assign w_v_ge_on  = !i_dc_v[31] && (i_dc_v[30:0] >= DC_ON_TH[30:0]);
   assign w_v_le_off =  i_dc_v[31] || (i_dc_v[30:0] <= DC_OFF_TH[30:0]);

   // Per-state wait condition and the state it advances to once debounced
   always_comb begin
      w_is_wait   = 1'b0;
      w_cond      = 1'b0;
      w_adv_state = r_state;
      case (r_state)
         ST_PHASE_CHK: begin w_is_wait = 1'b1; w_cond = i_phase_ok;            w_adv_state = ST_DIS_OFF;  end
         ST_DIS_OFF:   begin w_is_wait = 1'b1; w_cond = !i_dis_fb;             w_adv_state = ST_SLOW_ON;  end
         ST_SLOW_ON:   begin w_is_wait = 1'b1; w_cond = i_slow_fb;             w_adv_state = ST_DC_CHG;   end
         ST_DC_CHG:    begin w_is_wait = 1'b1; w_cond = w_v_ge_on;             w_adv_state = ST_MAIN_ON;  end
         ST_MAIN_ON:   begin w_is_wait = 1'b1; w_cond = i_main_fb;             w_adv_state = ST_SLOW_OFF; end
         ST_SLOW_OFF:  begin w_is_wait = 1'b1; w_cond = !i_slow_fb;            w_adv_state = ST_ON;       end
         ST_OFF_MAIN:  begin w_is_wait = 1'b1; w_cond = !i_main_fb && !i_slow_fb; w_adv_state = ST_OFF_DIS; end
         ST_OFF_DIS:   begin w_is_wait = 1'b1; w_cond = w_v_le_off;            w_adv_state = ST_IDLE;     end
         default: ;
      endcase
   end

   // The counter reads DEB_CYC-1 during the DEB_CYC-th consecutive true cycle
   assign w_deb_done  = w_is_wait && w_cond && (r_deb_cnt >= DEB_LAST);
   assign w_tmo_hit   = w_is_wait && (r_tmo_cnt >= TMO_LAST);
   assign w_abortable = (r_state >= ST_PHASE_CHK) && (r_state <= ST_ON);

   // Next state and fault code, highest priority first
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_fault_code;
      if (i_intl && (r_state != ST_FAULT)) begin
         w_state_nxt = ST_FAULT;
         w_code_nxt  = CODE_INTL;
      end else if (w_tmo_hit && !w_deb_done) begin
         w_state_nxt = ST_FAULT;
         w_code_nxt  = r_state;
      end else if ((r_state == ST_ON) && !i_main_fb) begin
         w_state_nxt = ST_FAULT;
         w_code_nxt  = CODE_MAIN;
      end else if (i_op_off && w_abortable) begin
         w_state_nxt = ST_OFF_MAIN;
      end else if (w_deb_done) begin
         w_state_nxt = w_adv_state;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_op_on && !i_op_off) w_state_nxt = ST_PHASE_CHK;
            end
            ST_FAULT: begin
               // A held interlock keeps the block in FAULT even when cleared
               if (i_fault_clr && !i_intl && w_v_le_off) begin
                  w_state_nxt = ST_IDLE;
                  w_code_nxt  = CODE_NONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_chg = (w_state_nxt != r_state);

   // Debounce and timeout counters: saturating, cleared on any state change
   always_comb begin
      w_deb_nxt = r_deb_cnt;
      w_tmo_nxt = r_tmo_cnt;
      if (w_chg || !w_is_wait) begin
         w_deb_nxt = '0;
         w_tmo_nxt = '0;
      end else begin
         if (!w_cond)                   w_deb_nxt = '0;
         else if (r_deb_cnt != CNT_MAX) w_deb_nxt = r_deb_cnt + 1'b1;
         if (r_tmo_cnt != CNT_MAX)      w_tmo_nxt = r_tmo_cnt + 1'b1;
      end
   end

   // Relay drives and status flags for the state being entered; states that
   // leave a drive unlisted keep its current value
   always_comb begin
      w_dis_nxt  = r_dis_on;
      w_slow_nxt = r_slow_on;
      w_main_nxt = r_main_on;
      if (w_chg) begin
         case (w_state_nxt)
            ST_IDLE:     begin w_dis_nxt = 1'b1; w_slow_nxt = 1'b0; w_main_nxt = 1'b0; end
            ST_DIS_OFF:  w_dis_nxt  = 1'b0;
            ST_SLOW_ON:  w_slow_nxt = 1'b1;
            ST_MAIN_ON:  w_main_nxt = 1'b1;
            ST_SLOW_OFF: w_slow_nxt = 1'b0;
            ST_OFF_MAIN: begin w_slow_nxt = 1'b0; w_main_nxt = 1'b0; end
            ST_OFF_DIS:  w_dis_nxt  = 1'b1;
            ST_FAULT:    begin w_dis_nxt = 1'b1; w_slow_nxt = 1'b0; w_main_nxt = 1'b0; end
            default: ;
         endcase
      end
      w_on_done_nxt  = (w_state_nxt == ST_ON);
      w_fault_nxt    = (w_state_nxt == ST_FAULT);
      w_off_done_nxt = (r_state == ST_OFF_DIS) && (w_state_nxt == ST_IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_deb_cnt    <= '0;
         r_tmo_cnt    <= '0;
         r_dis_on     <= 1'b1;
         r_slow_on    <= 1'b0;
         r_main_on    <= 1'b0;
         r_on_done    <= 1'b0;
         r_off_done   <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_code <= CODE_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_deb_cnt    <= w_deb_nxt;
         r_tmo_cnt    <= w_tmo_nxt;
         r_dis_on     <= w_dis_nxt;
         r_slow_on    <= w_slow_nxt;
         r_main_on    <= w_main_nxt;
         r_on_done    <= w_on_done_nxt;
         r_off_done   <= w_off_done_nxt;
         r_fault      <= w_fault_nxt;
         r_fault_code <= w_code_nxt;
      end
   end

   assign o_state      = r_state;
   assign o_dis_on     = r_dis_on;
   assign o_slow_on    = r_slow_on;
   assign o_main_on    = r_main_on;
   assign o_on_done    = r_on_done;
   assign o_off_done   = r_off_done;
   assign o_fault      = r_fault;
   assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_mps_pwr_seq_ctrl.sv
// Bench for mps_pwr_seq_ctrl: a plant model closes the feedback loops with a
// randomized relay delay, the stimulus thread queues the expected state
// entries, and a monitor pops and compares one entry per observed state change.
module tb_mps_pwr_seq_ctrl;

   localparam int DEB = 4;
   localparam int TMO = 200;
   localparam logic [31:0] V_281 = 32'h438C8000;
   localparam logic [31:0] V_260 = 32'h43820000;
   localparam logic [31:0] V_100 = 32'h42C80000;
   localparam logic [31:0] V_10  = 32'h41200000;
   localparam logic [31:0] V_9   = 32'h41100000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_on = 1'b0, op_off = 1'b0, intl = 1'b0, fclr = 1'b0;
   logic        phase_ok = 1'b0, dis_fb = 1'b1, slow_fb = 1'b0, main_fb = 1'b0;
   logic [31:0] dc_v = 32'h0;
   logic        dis_on, slow_on, main_on, on_done, off_done, fault;
   logic [3:0]  state, fault_code;

   mps_pwr_seq_ctrl #(
      .DEB_CYC(DEB), .TMO_CYC(TMO), .CNT_W(32),
      .DC_ON_TH(32'h43820000), .DC_OFF_TH(32'h41200000)
   ) u_dut (
      .i_clk(clk), .i_rst(rst_n), .i_op_on(op_on), .i_op_off(op_off),
      .i_intl(intl), .i_fault_clr(fclr), .i_phase_ok(phase_ok),
      .i_dis_fb(dis_fb), .i_slow_fb(slow_fb), .i_main_fb(main_fb), .i_dc_v(dc_v),
      .o_dis_on(dis_on), .o_slow_on(slow_on), .o_main_on(main_on),
      .o_state(state), .o_on_done(on_done), .o_off_done(off_done),
      .o_fault(fault), .o_fault_code(fault_code)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [3:0] st;
      logic [3:0] code;
      logic       dis, slow, main, on_d, flt, off_d;
      int         dwell;   // cycles spent in the previous state, -1 = any
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   logic m_dis = 1'b1, m_slow = 1'b0, m_main = 1'b0;

   // Reference model: relay drives on entry to each state, from the state table
   task automatic push_exp(input logic [3:0] st, input logic [3:0] code,
                           input logic offd, input int dwell);
      exp_t e;
      case (st)
         4'd0:  begin m_dis = 1'b1; m_slow = 1'b0; m_main = 1'b0; end
         4'd2:  m_dis  = 1'b0;
         4'd3:  m_slow = 1'b1;
         4'd5:  m_main = 1'b1;
         4'd6:  m_slow = 1'b0;
         4'd8:  begin m_slow = 1'b0; m_main = 1'b0; end
         4'd9:  m_dis  = 1'b1;
         4'd10: begin m_dis = 1'b1; m_slow = 1'b0; m_main = 1'b0; end
         default: ;
      endcase
      e.st = st; e.code = code; e.dis = m_dis; e.slow = m_slow; e.main = m_main;
      e.on_d = (st == 4'd7); e.flt = (st == 4'd10); e.off_d = offd; e.dwell = dwell;
      exp_q.push_back(e);
   endtask

   // Plant: each feedback follows its drive after dly clock cycles
   int         dly = 10;
   bit         plant_en = 1'b0;
   bit         main_open = 1'b0;
   logic [15:0] h_dis = 16'hFFFF, h_slow = 16'h0, h_main = 16'h0;
   initial forever begin
      @(negedge clk);
      h_dis  = {h_dis[14:0], dis_on};
      h_slow = {h_slow[14:0], slow_on};
      h_main = {h_main[14:0], main_on};
      if (plant_en) begin
         dis_fb  = h_dis[dly-1];
         slow_fb = h_slow[dly-1];
         main_fb = main_open ? 1'b0 : h_main[dly-1];
      end
   end

   // Monitor: every change of o_state must match the next queued entry
   initial begin
      exp_t e;
      logic [3:0] prev;
      int last;
      bit after;
      prev = 4'd0; last = 0; after = 1'b0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (!mon_en) begin
            prev = state; last = cyc;
         end else if (state !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_transition: state %0d -> %0d at cycle %0d, nothing expected", prev, state, cyc);
            end else begin
               e = exp_q.pop_front();
               if ({state, fault_code, dis_on, slow_on, main_on, on_done, fault, off_done} !==
                   {e.st, e.code, e.dis, e.slow, e.main, e.on_d, e.flt, e.off_d}) begin
                  errors++;
                  $display("FAIL entry_%0d: got st=%0d code=%0d dis=%b slow=%b main=%b on=%b flt=%b offd=%b, want st=%0d code=%0d dis=%b slow=%b main=%b on=%b flt=%b offd=%b",
                           e.st, state, fault_code, dis_on, slow_on, main_on, on_done, fault, off_done,
                           e.st, e.code, e.dis, e.slow, e.main, e.on_d, e.flt, e.off_d);
               end
               if (e.dwell >= 0) begin
                  checks++;
                  if (cyc - last != e.dwell) begin
                     errors++;
                     $display("FAIL dwell_before_%0d: got %0d cycles in state %0d, want %0d", e.st, cyc - last, prev, e.dwell);
                  end
               end
            end
            prev = state; last = cyc; after = 1'b1;
         end else if (after) begin
            checks++;
            if (off_done !== 1'b0) begin
               errors++;
               $display("FAIL off_done_width: got %b one cycle after entry, want 0", off_done);
            end
            after = 1'b0;
         end
      end
   end

   task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget);
      int n = 0;
      while (state !== s && n < budget) begin @(negedge clk); n++; end
      checks++;
      if (state !== s) begin
         errors++;
         $display("FAIL wait_state_%0d: got state %0d after %0d cycles, want %0d", s, state, budget, s);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0 (next st=%0d)", exp_q.size(), exp_q[0].st);
         exp_q.delete();
      end
   endtask

   task automatic pulse_on();  op_on  = 1'b1; @(negedge clk); op_on  = 1'b0; endtask
   task automatic pulse_off(); op_off = 1'b1; @(negedge clk); op_off = 1'b0; endtask
   task automatic pulse_clr(); fclr   = 1'b1; @(negedge clk); fclr   = 1'b0; endtask

   task automatic run_on(input int d, input logic [31:0] v_final);
      dly = d; phase_ok = 1'b1; dc_v = 32'h0;
      push_exp(4'd1, 4'd0, 1'b0, -1);
      push_exp(4'd2, 4'd0, 1'b0, DEB);
      push_exp(4'd3, 4'd0, 1'b0, -1);
      push_exp(4'd4, 4'd0, 1'b0, -1);
      push_exp(4'd5, 4'd0, 1'b0, -1);
      push_exp(4'd6, 4'd0, 1'b0, -1);
      push_exp(4'd7, 4'd0, 1'b0, -1);
      pulse_on();
      wait_state(4'd4, 300);
      repeat (20) begin
         dc_v = 32'h43000000 | ($urandom & 32'h007FFFFF);
         @(negedge clk);
      end
      dc_v = 32'h4381FFFF;
      repeat (6) @(negedge clk);
      dc_v = v_final;
      wait_state(4'd7, 300);
      drain(50);
      check_now("on_outputs", {28'h0, on_done, main_on, slow_on, dis_on}, 32'b1100);
   endtask

   task automatic run_off();
      push_exp(4'd8, 4'd0, 1'b0, -1);
      push_exp(4'd9, 4'd0, 1'b0, -1);
      push_exp(4'd0, 4'd0, 1'b1, DEB);
      dc_v = V_9;
      pulse_off();
      wait_state(4'd0, 300);
      drain(10);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pat [8];
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check_now("reset_state", {18'h0, state, fault_code, dis_on, slow_on, main_on, on_done, fault, off_done},
                {18'h0, 4'd0, 4'd0, 1'b1, 5'b0});
      rst_n = 1'b1; plant_en = 1'b1; mon_en = 1'b1;
      @(negedge clk);

      // on and off together in IDLE are ignored
      op_on = 1'b1; op_off = 1'b1; @(negedge clk); op_on = 1'b0; op_off = 1'b0;
      repeat (3) @(negedge clk);
      check_now("idle_on_off_both", {28'h0, state}, 32'd0);

      // full on/off cycles, randomized relay delay, one ending exactly at 260 V
      for (int i = 0; i < 3; i++) begin
         run_on((i == 0) ? 10 : int'($urandom_range(2, 12)), (i == 1) ? V_260 : V_281);
         run_off();
      end

      // timeout in DC_CHG, then clear gated by DC-link voltage
      dly = $urandom_range(2, 12); phase_ok = 1'b1; dc_v = V_100;
      push_exp(4'd1, 4'd0, 1'b0, -1);
      push_exp(4'd2, 4'd0, 1'b0, DEB);
      push_exp(4'd3, 4'd0, 1'b0, -1);
      push_exp(4'd4, 4'd0, 1'b0, -1);
      push_exp(4'd10, 4'd4, 1'b0, TMO);
      pulse_on();
      wait_state(4'd10, 600);
      drain(10);
      check_now("tmo_relays_safe", {29'h0, main_on, slow_on, dis_on}, 32'b001);
      dc_v = 32'h41300000 + $urandom_range(0, 32'h024FFFFF);
      repeat (15) @(negedge clk);
      pulse_clr(); repeat (3) @(negedge clk);
      check_now("clr_ignored_high_v", {24'h0, state, fault_code}, {24'h0, 4'd10, 4'd4});
      dc_v = 32'h41200001;
      pulse_clr(); repeat (3) @(negedge clk);
      check_now("clr_ignored_just_above", {24'h0, state, fault_code}, {24'h0, 4'd10, 4'd4});
      dc_v = V_10;
      push_exp(4'd0, 4'd0, 1'b0, -1);
      pulse_clr();
      wait_state(4'd0, 10);
      drain(5);

      // interlock in SLOW_ON; on request and held interlock block the exit
      dly = $urandom_range(2, 12); dc_v = 32'h0;
      push_exp(4'd1, 4'd0, 1'b0, -1);
      push_exp(4'd2, 4'd0, 1'b0, DEB);
      push_exp(4'd3, 4'd0, 1'b0, -1);
      pulse_on();
      wait_state(4'd3, 300);
      push_exp(4'd10, 4'd15, 1'b0, 1);
      intl = 1'b1; @(negedge clk); intl = 1'b0;
      wait_state(4'd10, 5);
      drain(5);
      pulse_on(); repeat (3) @(negedge clk);
      check_now("fault_ignores_on", {24'h0, state, fault_code}, {24'h0, 4'd10, 4'd15});
      intl = 1'b1; dc_v = 32'h80000000;
      pulse_clr(); repeat (2) @(negedge clk);
      check_now("clr_blocked_by_intl", {28'h0, state}, 32'd10);
      intl = 1'b0; @(negedge clk);
      push_exp(4'd0, 4'd0, 1'b0, -1);
      pulse_clr();
      wait_state(4'd0, 10);
      drain(5);

      // debounce pattern in PHASE_CHK, then abort from DIS_OFF
      dly = $urandom_range(2, 12); phase_ok = 1'b0; dc_v = V_10;
      repeat (15) @(negedge clk);
      push_exp(4'd1, 4'd0, 1'b0, -1);
      push_exp(4'd2, 4'd0, 1'b0, 8);
      pulse_on();
      for (int k = 0; k < 8; k++) begin phase_ok = pat[k]; @(negedge clk); end
      wait_state(4'd2, 5);
      drain(5);
      push_exp(4'd8, 4'd0, 1'b0, -1);
      push_exp(4'd9, 4'd0, 1'b0, DEB);
      push_exp(4'd0, 4'd0, 1'b1, DEB);
      pulse_off();
      wait_state(4'd0, 50);
      drain(5);

      // synchronous reset in MAIN_ON, then a fresh start debounces from zero
      dly = $urandom_range(2, 12); phase_ok = 1'b1; dc_v = V_281;
      push_exp(4'd1, 4'd0, 1'b0, -1);
      push_exp(4'd2, 4'd0, 1'b0, DEB);
      push_exp(4'd3, 4'd0, 1'b0, -1);
      push_exp(4'd4, 4'd0, 1'b0, -1);
      push_exp(4'd5, 4'd0, 1'b0, -1);
      pulse_on();
      wait_state(4'd5, 300);
      push_exp(4'd0, 4'd0, 1'b0, 1);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      wait_state(4'd0, 3);
      drain(3);
      check_now("after_reset", {26'h0, dis_on, main_on, fault_code}, {26'h0, 1'b1, 1'b0, 4'd0});
      push_exp(4'd1, 4'd0, 1'b0, -1);
      push_exp(4'd2, 4'd0, 1'b0, DEB);
      pulse_on();
      wait_state(4'd2, 50);
      push_exp(4'd8, 4'd0, 1'b0, -1);
      push_exp(4'd9, 4'd0, 1'b0, -1);
      push_exp(4'd0, 4'd0, 1'b1, DEB);
      dc_v = V_9;
      pulse_off();
      wait_state(4'd0, 100);
      drain(5);

      // main contactor feedback lost while ON
      run_on($urandom_range(2, 12), V_281);
      push_exp(4'd10, 4'd7, 1'b0, -1);
      main_open = 1'b1;
      wait_state(4'd10, 30);
      drain(5);
      main_open = 1'b0; dc_v = V_9;
      repeat (15) @(negedge clk);
      push_exp(4'd0, 4'd0, 1'b0, -1);
      pulse_clr();
      wait_state(4'd0, 10);
      drain(5);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
